// File: rtl/ctrl_pipe.sv
// ctrl_pipe: consumer end of the decode-stage control bundle.
// Carries the control word and register addresses of each instruction
// through the ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts
// bubbles on load-use hazards and EX-resolved flushes. It also produces
// the load-use stall and the EX-stage operand forwarding selects.
//
// Control word layout:
//   {regwrite[11], alusrc[10], memwrite[9], wdsel[8:7],
//    resultsrc[6:5], jumpsel[4], alucontrol[3:0]}
//
// Optional build macro: CTRL_PIPE_RETIRE_CNT_EN
//   Defined   : retire_cnt counts the cycles in which WB holds a valid
//               instruction. It wraps at 2^CNT_W.
//   Undefined : retire_cnt is tied to zero and no counter flops exist.
module ctrl_pipe #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [11:0]      d_ctrl,
  input  logic [RA_W-1:0]  d_rd,
  input  logic [RA_W-1:0]  d_rs1,
  input  logic [RA_W-1:0]  d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             e_valid,
  output logic             m_valid,
  output logic             w_valid,
  output logic [11:0]      e_ctrl,
  output logic [11:0]      m_ctrl,
  output logic [11:0]      w_ctrl,
  output logic [RA_W-1:0]  e_rd,
  output logic [RA_W-1:0]  m_rd,
  output logic [RA_W-1:0]  w_rd,
  output logic [RA_W-1:0]  e_rs1,
  output logic [RA_W-1:0]  e_rs2,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int              REGWRITE = 11;
  localparam logic [1:0]      RES_LOAD = 2'b01;
  localparam logic [1:0]      FWD_RF   = 2'b00;
  localparam logic [1:0]      FWD_WB   = 2'b01;
  localparam logic [1:0]      FWD_MEM  = 2'b10;
  localparam logic [RA_W-1:0] REG_X0   = '0;

  logic        e_is_load;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        hz;
  logic        e_take;
  logic [11:0] d_ctrl_cap;
  logic        m_fwd_ok;
  logic        w_fwd_ok;

  // Load-use hazard against the instruction in EX. A flush wins over the
  // stall so that fetch can redirect. Both sources hitting still costs
  // only one stall cycle, because EX becomes a bubble next cycle.
  always_comb begin
    e_is_load = e_valid & e_ctrl[REGWRITE] & (e_ctrl[6:5] == RES_LOAD);
    rs1_hit   = d_use_rs1 & (d_rs1 == e_rd);
    rs2_hit   = d_use_rs2 & (d_rs2 == e_rd);
    hz        = e_is_load & (rs1_hit | rs2_hit);
    stall_o   = hz & ~flush_i & d_valid;
    e_take    = d_valid & ~flush_i & ~stall_o;
  end

  // Writes to x0 are dropped at capture, so downstream logic never
  // sees a regwrite that targets x0.
  always_comb begin
    d_ctrl_cap           = d_ctrl;
    d_ctrl_cap[REGWRITE] = d_ctrl[REGWRITE] & (d_rd != REG_X0);
  end

  // EX operand forwarding. MEM wins over WB. A load in MEM has no data
  // yet, so it is never a forwarding source. Requiring a nonzero
  // producer rd also makes e_rs1/e_rs2 == x0 always select the register file.
  always_comb begin
    m_fwd_ok = m_valid & m_ctrl[REGWRITE] & (m_ctrl[6:5] != RES_LOAD) & (m_rd != REG_X0);
    w_fwd_ok = w_valid & w_ctrl[REGWRITE] & (w_rd != REG_X0);
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    if (m_fwd_ok && (m_rd == e_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (w_fwd_ok && (w_rd == e_rs1)) begin
      fwd_a = FWD_WB;
    end
    if (m_fwd_ok && (m_rd == e_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (w_fwd_ok && (w_rd == e_rs2)) begin
      fwd_b = FWD_WB;
    end
  end

  // ID/EX register: capture the decode slot, or insert a bubble on a
  // stall, a flush or an empty decode slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_rd    <= '0;
      e_rs1   <= '0;
      e_rs2   <= '0;
    end else if (e_take) begin
      e_valid <= 1'b1;
      e_ctrl  <= d_ctrl_cap;
      e_rd    <= d_rd;
      e_rs1   <= d_rs1;
      e_rs2   <= d_rs2;
    end else begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_rd    <= '0;
      e_rs1   <= '0;
      e_rs2   <= '0;
    end
  end

  // EX/MEM register: always advances. The branch that raised the flush
  // still moves on to MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_rd    <= '0;
    end else begin
      m_valid <= e_valid;
      m_ctrl  <= e_ctrl;
      m_rd    <= e_rd;
    end
  end

  // MEM/WB register: always advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_ctrl  <= '0;
      w_rd    <= '0;
    end else begin
      w_valid <= m_valid;
      w_ctrl  <= m_ctrl;
      w_rd    <= m_rd;
    end
  end

`ifdef CTRL_PIPE_RETIRE_CNT_EN
  // Retired-instruction counter. It wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (w_valid) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table, a retire-counter sequence and a
// randomized run. All three are checked against a reference model of the
// pipeline kept in the bench.
module tb_ctrl_pipe;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             d_valid;
  logic [11:0]      d_ctrl;
  logic [RA_W-1:0]  d_rd;
  logic [RA_W-1:0]  d_rs1;
  logic [RA_W-1:0]  d_rs2;
  logic             d_use_rs1;
  logic             d_use_rs2;
  logic             flush_i;
  logic             stall_o;
  logic             e_valid;
  logic             m_valid;
  logic             w_valid;
  logic [11:0]      e_ctrl;
  logic [11:0]      m_ctrl;
  logic [11:0]      w_ctrl;
  logic [RA_W-1:0]  e_rd;
  logic [RA_W-1:0]  m_rd;
  logic [RA_W-1:0]  w_rd;
  logic [RA_W-1:0]  e_rs1;
  logic [RA_W-1:0]  e_rs2;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] retire_cnt;

  ctrl_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ctrl(d_ctrl),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .flush_i(flush_i),
    .stall_o(stall_o), .e_valid(e_valid), .m_valid(m_valid), .w_valid(w_valid),
    .e_ctrl(e_ctrl), .m_ctrl(m_ctrl), .w_ctrl(w_ctrl),
    .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one record per occupied stage.
  typedef struct packed {
    logic        v;
    logic [11:0] c;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stg_t;

  stg_t       me, mm, mw;
  logic [3:0] mcnt;
  bit         mknown = 0;
  logic       mstall;

  function automatic logic [1:0] model_fwd(input logic [4:0] src, input stg_t m, input stg_t w);
    bit m_is_load;
    m_is_load = (m.c[6:5] == 2'b01);
    if (src == 5'd0) return 2'b00;
    if (m.v && m.c[11] && m.rd == src && !m_is_load) return 2'b10;
    if (w.v && w.c[11] && w.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall();
    bit load_in_e, dep;
    load_in_e = me.v && me.c[11] && (me.c[6:5] == 2'b01);
    dep = (d_use_rs1 && d_rs1 == me.rd) || (d_use_rs2 && d_rs2 == me.rd);
    return load_in_e && dep && !flush_i && d_valid;
  endfunction

  task automatic drive(input logic r, input logic dv, input logic [11:0] c,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic fl);
    reset = r; d_valid = dv; d_ctrl = c; d_rd = rd; d_rs1 = rs1; d_rs2 = rs2;
    d_use_rs1 = u1; d_use_rs2 = u2; flush_i = fl;
  endtask

  // One clock: check the combinational outputs before the edge, advance
  // the model at the edge, then check the registered outputs after it.
  task automatic tick();
    stg_t nx;
    #1;
    mstall = model_stall();
    if (mknown) begin
      check("stall_o", 32'(stall_o), 32'(mstall));
      check("fwd_a", 32'(fwd_a), 32'(model_fwd(me.rs1, mm, mw)));
      check("fwd_b", 32'(fwd_b), 32'(model_fwd(me.rs2, mm, mw)));
    end
    @(posedge clk);
    if (reset) begin
      me = '0; mm = '0; mw = '0; mcnt = 4'd0; mknown = 1;
    end else begin
      if (mw.v) mcnt = mcnt + 4'd1;
      nx = '0;
      if (d_valid && !flush_i && !mstall) begin
        nx.v = 1'b1; nx.c = d_ctrl; nx.c[11] = d_ctrl[11] && (d_rd != 5'd0);
        nx.rd = d_rd; nx.rs1 = d_rs1; nx.rs2 = d_rs2;
      end
      mw = mm; mm = me; me = nx;
    end
    #1;
    if (mknown) begin
      check("e_stage", 32'({e_valid, e_ctrl, e_rd, e_rs1, e_rs2}), 32'({me.v, me.c, me.rd, me.rs1, me.rs2}));
      check("m_stage", 32'({m_valid, m_ctrl, m_rd}), 32'({mm.v, mm.c, mm.rd}));
      check("w_stage", 32'({w_valid, w_ctrl, w_rd}), 32'({mw.v, mw.c, mw.rd}));
`ifdef CTRL_PIPE_RETIRE_CNT_EN
      check("retire_cnt", 32'(retire_cnt), 32'(mcnt));
`else
      check("retire_cnt", 32'(retire_cnt), 32'd0);
`endif
    end
  endtask

  typedef struct {
    logic rst, dv; logic [11:0] c; logic [4:0] rd, rs1, rs2; logic u1, u2, fl;
    logic pre, xs; logic [1:0] xfa, xfb;
    logic xev; logic [11:0] xec; logic [4:0] xerd; logic xwv;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  initial begin
    // rst dv ctrl rd rs1 rs2 u1 u2 fl | pre stall fa fb | e_valid e_ctrl e_rd w_valid
    tbl[0]  = '{1'b1,1'b1,12'h800,5'd5, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b0};
    tbl[1]  = '{1'b1,1'b1,12'h800,5'd5, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b0};
    tbl[2]  = '{1'b0,1'b1,12'h800,5'd5, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h800,5'd5, 1'b0};
    tbl[3]  = '{1'b0,1'b0,12'h000,5'd0, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b0};
    tbl[4]  = '{1'b0,1'b0,12'h000,5'd0, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b1};
    tbl[5]  = '{1'b0,1'b1,12'h800,5'd0, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h000,5'd0, 1'b0};
    tbl[6]  = '{1'b0,1'b1,12'h820,5'd7, 5'd1,5'd2,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h820,5'd7, 1'b0};
    tbl[7]  = '{1'b0,1'b1,12'h800,5'd8, 5'd7,5'd0,1'b1,1'b0,1'b0, 1'b1,1'b1,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b1};
    tbl[8]  = '{1'b0,1'b1,12'h800,5'd8, 5'd7,5'd0,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h800,5'd8, 1'b1};
    tbl[9]  = '{1'b0,1'b0,12'h000,5'd0, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd1,2'd0, 1'b0,12'h000,5'd0, 1'b0};
    tbl[10] = '{1'b0,1'b1,12'h820,5'd9, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h820,5'd9, 1'b1};
    tbl[11] = '{1'b0,1'b1,12'h800,5'd10,5'd9,5'd9,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b0};
    tbl[12] = '{1'b0,1'b1,12'h800,5'd10,5'd9,5'd9,1'b1,1'b1,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h800,5'd10,1'b1};
    tbl[13] = '{1'b0,1'b1,12'h800,5'd3, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd1,2'd1, 1'b1,12'h800,5'd3, 1'b0};
    tbl[14] = '{1'b0,1'b1,12'h800,5'd3, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h800,5'd3, 1'b1};
    tbl[15] = '{1'b0,1'b1,12'h800,5'd11,5'd3,5'd3,1'b1,1'b1,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h800,5'd11,1'b1};
    tbl[16] = '{1'b0,1'b1,12'h800,5'd12,5'd3,5'd3,1'b1,1'b1,1'b0, 1'b1,1'b0,2'd2,2'd2, 1'b1,12'h800,5'd12,1'b1};
    tbl[17] = '{1'b0,1'b0,12'h000,5'd0, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd1,2'd1, 1'b0,12'h000,5'd0, 1'b1};
    tbl[18] = '{1'b0,1'b1,12'h820,5'd4, 5'd0,5'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h820,5'd4, 1'b1};
    tbl[19] = '{1'b0,1'b1,12'h800,5'd13,5'd4,5'd4,1'b1,1'b1,1'b0, 1'b1,1'b1,2'd0,2'd0, 1'b0,12'h000,5'd0, 1'b0};
    tbl[20] = '{1'b0,1'b1,12'h800,5'd13,5'd4,5'd4,1'b1,1'b1,1'b0, 1'b1,1'b0,2'd0,2'd0, 1'b1,12'h800,5'd13,1'b1};
    tbl[21] = '{1'b1,1'b1,12'h800,5'd1, 5'd2,5'd3,1'b1,1'b1,1'b0, 1'b1,1'b0,2'd1,2'd1, 1'b0,12'h000,5'd0, 1'b0};

    drive(1'b1, 1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Directed vectors: reset, x0 masking, load-use, flush, forwarding priority.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].dv, tbl[i].c, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].u1, tbl[i].u2, tbl[i].fl);
      #1;
      if (tbl[i].pre) begin
        check($sformatf("vec%0d stall", i), 32'(stall_o), 32'(tbl[i].xs));
        check($sformatf("vec%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].xfa));
        check($sformatf("vec%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].xfb));
      end
      tick();
      check($sformatf("vec%0d e_valid", i), 32'(e_valid), 32'(tbl[i].xev));
      check($sformatf("vec%0d e_ctrl", i), 32'(e_ctrl), 32'(tbl[i].xec));
      check($sformatf("vec%0d e_rd", i), 32'(e_rd), 32'(tbl[i].xerd));
      check($sformatf("vec%0d w_valid", i), 32'(w_valid), 32'(tbl[i].xwv));
    end

    // Retire counter: 17 valid instructions, then drain with bubbles.
    drive(1'b1, 1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 12'h800, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
`ifdef CTRL_PIPE_RETIRE_CNT_EN
    check("retire_wrap", 32'(retire_cnt), 32'd1);
`else
    check("retire_off", 32'(retire_cnt), 32'd0);
`endif

    // Randomized run. A stalled instruction is re-presented, as upstream would do.
    for (int i = 0; i < 3000; i++) begin
      if (!mstall || flush_i || reset) begin
        reset     = ($urandom_range(299) == 0);
        d_valid   = ($urandom_range(9) != 0);
        d_ctrl    = 12'($urandom);
        d_ctrl[11] = ($urandom_range(3) != 0);
        if ($urandom_range(2) == 0) d_ctrl[6:5] = 2'b01;
        d_rd      = 5'($urandom_range(3));
        d_rs1     = 5'($urandom_range(3));
        d_rs2     = 5'($urandom_range(3));
        d_use_rs1 = ($urandom_range(3) != 0);
        d_use_rs2 = ($urandom_range(1) != 0);
      end
      flush_i = ($urandom_range(9) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
